// File: rtl/fir.sv
// fir: 4-tap unsigned FIR with one serial MAC; go rising edge captures in, y holds the saturated 16-bit result
module fir #(
  parameter logic [7:0] C0 = 8'd1,
  parameter logic [7:0] C1 = 8'd2,
  parameter logic [7:0] C2 = 8'd3,
  parameter logic [7:0] C3 = 8'd4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in,
  input  logic        go,
  output logic [15:0] y
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_n;
  logic [7:0] x0, x1, x2, x3, xs, cs;
  logic [19:0] acc;
  logic [15:0] prod;
  logic [1:0] idx;
  logic go_q, start;
  assign start = go & ~go_q;
  always_comb begin
    xs = idx == 2'd0 ? x0 : idx == 2'd1 ? x1 : idx == 2'd2 ? x2 : x3;
    cs = idx == 2'd0 ? C0 : idx == 2'd1 ? C1 : idx == 2'd2 ? C2 : C3;
    prod = 16'(xs) * 16'(cs);
    state_n = state == IDLE ? (start ? MAC : IDLE) :
              state == MAC  ? (idx == 2'd3 ? DONE : MAC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q <= 1'b0;
      x0 <= '0;
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      acc <= '0;
      idx <= '0;
      y <= '0;
    end else begin
      go_q <= go;
      if (state == IDLE && start) begin
        x3 <= x2;
        x2 <= x1;
        x1 <= x0;
        x0 <= in;
        acc <= '0;
        idx <= '0;
      end
      if (state == MAC) begin
        acc <= acc + {4'd0, prod};
        idx <= idx + 2'd1;
      end
      if (state == DONE) y <= acc > 20'hFFFF ? 16'hFFFF : acc[15:0];
    end
  end
endmodule

// File: tb/tb_fir.sv
// tb_fir: directed and random checks of fir (default and all-255 coefficients) against an arithmetic model
module tb_fir;
  logic clk = 0, rst = 0, go = 0;
  logic [7:0] in = 0;
  logic [15:0] y_def, y_sat;
  int checks = 0, errors = 0;
  int hist[4];
  int exp_def = 0, exp_sat = 0;
  always #5 clk = ~clk;
  fir u_def (.clk(clk), .rst(rst), .in(in), .go(go), .y(y_def));
  fir #(.C0(8'd255), .C1(8'd255), .C2(8'd255), .C3(8'd255))
    u_sat (.clk(clk), .rst(rst), .in(in), .go(go), .y(y_sat));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < 4; i++) hist[i] = 0;
  endtask
  task automatic push(input int v);
    int sd, ss;
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = v;
    sd = hist[0] * 1 + hist[1] * 2 + hist[2] * 3 + hist[3] * 4;
    ss = (hist[0] + hist[1] + hist[2] + hist[3]) * 255;
    exp_def = sd > 65535 ? 65535 : sd;
    exp_sat = ss > 65535 ? 65535 : ss;
  endtask
  task automatic check_both(input string tag);
    chk({tag, "_def"}, 32'(y_def), 32'(exp_def));
    chk({tag, "_sat"}, 32'(y_sat), 32'(exp_sat));
  endtask
  task automatic fire(input logic [7:0] v, input int extra);
    int od, os;
    @(negedge clk);
    in = v;
    go = 1;
    od = exp_def;
    os = exp_sat;
    push(int'(v));
    @(posedge clk);
    @(negedge clk);
    go = 0;
    in = 8'($urandom);
    repeat (4) @(posedge clk);
    #1;
    chk("hold_e4_def", 32'(y_def), 32'(od));
    chk("hold_e4_sat", 32'(y_sat), 32'(os));
    @(posedge clk);
    #1;
    check_both("update_e5");
    repeat (extra) @(posedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_immediate", 32'(y_def), 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    clear_model();
    exp_def = 0;
    exp_sat = 0;
  endtask
  initial begin
    clear_model();
    #2 rst = 1;
    #1;
    chk("rst_async_def", 32'(y_def), 32'd0);
    chk("rst_async_sat", 32'(y_sat), 32'd0);
    @(negedge clk);
    go = 1;
    in = 8'd99;
    repeat (2) @(negedge clk);
    go = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) check_both("idle_after_rst");
    end
    for (int i = 0; i < 5; i++) fire(8'd1, 2);
    for (int i = 0; i < 4; i++) fire(8'd255, 1);
    for (int i = 0; i < 4; i++) fire(8'd0, 0);
    @(negedge clk);
    rst = 1;
    go = 1;
    in = 8'd7;
    repeat (2) @(negedge clk);
    rst = 0;
    clear_model();
    push(7);
    repeat (20) @(negedge clk);
    check_both("go_held");
    go = 0;
    repeat (3) @(negedge clk);
    check_both("go_held_after");
    do_reset();
    @(negedge clk);
    in = 8'd7;
    go = 1;
    push(7);
    @(negedge clk);
    go = 0;
    @(negedge clk);
    go = 1;
    in = 8'd9;
    @(negedge clk);
    go = 0;
    repeat (6) @(negedge clk);
    check_both("ignored_edge");
    repeat (4) @(negedge clk);
    check_both("ignored_edge_late");
    fire(8'd3, 0);
    @(negedge clk);
    in = 8'd50;
    go = 1;
    @(posedge clk);
    @(negedge clk);
    go = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid_mac_rst_def", 32'(y_def), 32'd0);
    chk("mid_mac_rst_sat", 32'(y_sat), 32'd0);
    @(negedge clk);
    rst = 0;
    clear_model();
    exp_def = 0;
    exp_sat = 0;
    repeat (8) @(negedge clk);
    check_both("after_abort");
    fire(8'd5, 0);
    for (int i = 0; i < 30; i++) fire(8'($urandom), int'($urandom_range(0, 4)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir.md
# fir

Four-tap direct-form FIR filter with unsigned 8-bit samples and a 16-bit saturated output. Each rising edge on `go` accepts one new sample. The block then computes the dot product of the delay line with the coefficients using a single serial multiply-accumulate (MAC) over four clocks. The block sits between a sample source that strobes `go` and downstream logic that reads `y` as a held register.

## Interface
Parameters:
- `C0`, default 1, 8-bit unsigned coefficient for the newest sample x[n].
- `C1`, default 2, coefficient for x[n-1].
- `C2`, default 3, coefficient for x[n-2].
- `C3`, default 4, coefficient for x[n-3].

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in`  input  8  unsigned sample, captured when a `go` rising edge is detected.
- `go`  input  1  sample strobe, level input; only its rising edge acts.
- `y`  output  16  registered filter result, held between updates.

## Operation
- Delay line: four 8-bit registers x0..x3, with x0 the newest.
- Edge detect: `go_q` registers `go` every clock. The start condition is `go & ~go_q`.
- FSM states: IDLE, MAC, DONE.
- **IDLE**: on the start condition:
  - shift the delay line (x3<=x2, x2<=x1, x1<=x0, x0<=in);
  - clear the 20-bit accumulator and set the tap index to 0;
  - go to MAC.
- **MAC**: each clock, acc <= acc + x[idx]*C[idx] using one 8x8->16 unsigned multiplier, then idx increments. After idx=3 the FSM goes to DONE.
- **DONE**: y <= (acc > 16'hFFFF) ? 16'hFFFF : acc[15:0], then go to IDLE.
- Start conditions outside IDLE are ignored, not queued. `go_q` still tracks `go`, so holding `go` high never retriggers.
- Arithmetic is unsigned throughout, with no rounding or scaling. With default coefficients the maximum result is 255*10 = 2550, so no saturation occurs.

## Timing
- Reset values: `y`=0, x0..x3=0, acc=0, idx=0, `go_q`=0, FSM=IDLE. Reset takes effect immediately and asynchronously.
- Latency: let the start condition be seen at clock edge E.
  - Sample shifts at E.
  - MAC runs at E+1..E+4.
  - `y` updates at E+5.
  - The next start is accepted at E+6 or later (the FSM must be back in IDLE).
- Throughput: at most one sample per 6 clocks.
- `y` changes only in DONE, and is otherwise constant.
- Reset asserted mid-MAC: the computation is aborted, all state clears, and `y` reads 0. The sample in flight is lost.
- `go` high at reset release: `go_q`=0, so the first clock after release counts as a rising edge and starts a sample.
- `in` is sampled only at the start edge. Changes during MAC do not affect the result.

## Test plan
- Reset with `go`=0: `y`=0 immediately and through 20 idle clocks. Pulse `go` during reset: `y` stays 0.
- Default coefficients, `in`=1, four `go` pulses spaced 8 clocks apart: `y` reads 1, 3, 6, 10, each update exactly 5 clocks after the start edge. A fifth pulse with `in`=1 still gives `y`=10.
- `in`=255 for four pulses: `y`=255, 765, 1530, 2550. Then `in`=0 for four pulses: `y`=2295, 1785, 1020, 0.
- Hold `go` high for 20 clocks with `in`=7: exactly one computation, `y`=7. A second `go` rising edge 2 clocks after the first (during MAC) is ignored, so `y` stays 7.
- Saturation, C0..C3=255, `in`=255 for four pulses: `y`=65025 then 65535, 65535, 65535 (saturated, no wrap).
- Assert `rst` 2 clocks after a start edge: `y`=0 immediately. After release, one pulse with `in`=5 gives `y`=5, proving the delay line was cleared.
